rr_enc_arbiter: RTL and testbench

- Round-robin arbiter sharing one resource among 2**IDX_LEN requesters.
- Uses a rotating priority encoder to pick the next owner.
- Registers the grant as one-hot plus binary index, with a valid flag in the same one-hot/index/valid style as the encoders.
- Enforces an optional maximum hold time so no requester can starve the others.

---
 rtl/rr_enc_arbiter_pkg.sv | 14 +
 rtl/rr_enc_arbiter_pick.sv | 33 +++
 rtl/rr_enc_arbiter.sv | 80 ++++++++
 tb/tb_rr_enc_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rr_enc_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and requester count.
package rr_enc_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Number of requesters addressed by an index of the given width.
  function automatic int num_req(input int idx_len);
    return 1 << idx_len;
  endfunction

endpackage

// File: rtl/rr_enc_arbiter_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping mod N.
module rr_pick
  import rr_enc_arbiter_pkg::*;
#(
  parameter int IDX_LEN = 3,
  localparam int N = num_req(IDX_LEN)
) (
  input  logic [N-1:0]       req,
  input  logic [IDX_LEN-1:0] ptr,
  output logic [IDX_LEN-1:0] id,
  output logic               v
);

  logic [2*N-1:0]     dbl;
  logic [N-1:0]       rot;
  logic [IDX_LEN-1:0] off;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N-1:0];
    off = '0;
    v   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_LEN'(i);
        v   = 1'b1;
      end
    end
    id = off + ptr;
  end

endmodule

// File: rtl/rr_enc_arbiter.sv
// Round-robin arbiter with registered one-hot/index/valid grant and optional hold limit.
// state   | meaning
// IDLE    | no owner; arbitrate among current requests (also the dead cycle after a release)
// BUSY    | gnt_id owns the resource until it drops its request or hits the hold limit
module rr_enc_arbiter
  import rr_enc_arbiter_pkg::*;
#(
  parameter int IDX_LEN  = 3,
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 8,
  localparam int N = num_req(IDX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  output logic [N-1:0]       gnt,
  output logic [IDX_LEN-1:0] gnt_id,
  output logic               gnt_v
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e         state;
  logic [IDX_LEN-1:0] ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [IDX_LEN-1:0] pick_id;
  logic               pick_v;
  logic               owner_drop;
  logic               hold_hit;

  rr_pick #(.IDX_LEN(IDX_LEN)) u_pick (
    .req (req),
    .ptr (ptr),
    .id  (pick_id),
    .v   (pick_v)
  );

  // Release conditions for the current owner; both lead to the same update.
  always_comb begin
    owner_drop = !req[gnt_id];
    hold_hit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  end

  // Arbitration FSM with registered grant outputs; release always lands in IDLE for one gap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      gnt_v    <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_v) begin
            state    <= ST_BUSY;
            gnt      <= {{(N-1){1'b0}}, 1'b1} << pick_id;
            gnt_id   <= pick_id;
            gnt_v    <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_BUSY: begin
          if (owner_drop || hold_hit) begin
            state  <= ST_IDLE;
            gnt    <= '0;
            gnt_id <= '0;
            gnt_v  <= 1'b0;
            ptr    <= gnt_id + IDX_LEN'(1);
          end else if (hold_cnt != {CNT_W{1'b1}}) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_enc_arbiter.sv
// Directed bench for rr_enc_arbiter: one unlimited-hold instance and one MAX_HOLD=4 instance.
module tb_rr_enc_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] gnt_id_a, gnt_id_b;
  logic       gnt_v_a, gnt_v_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         sel;
    logic       v;
    logic [2:0] id;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_enc_arbiter #(.IDX_LEN(3), .MAX_HOLD(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(gnt_id_a), .gnt_v(gnt_v_a)
  );

  rr_enc_arbiter #(.IDX_LEN(3), .MAX_HOLD(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(gnt_id_b), .gnt_v(gnt_v_b)
  );

  always @(posedge clk) begin
    if (!rst) assert (!$isunknown(req_a) && !$isunknown(req_b)) else $error("req has X/Z");
  end

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit sel, input logic v, input logic [2:0] id, input string tag);
    logic [7:0] exp_gnt;
    logic [7:0] one;
    one     = 8'd1;
    exp_gnt = v ? (one << id) : 8'd0;
    if (sel) begin
      cmp({tag, "_gnt"}, gnt_b, exp_gnt);
      cmp({tag, "_id"}, {5'd0, gnt_id_b}, v ? {5'd0, id} : 8'd0);
      cmp({tag, "_v"}, {7'd0, gnt_v_b}, {7'd0, v});
    end else begin
      cmp({tag, "_gnt"}, gnt_a, exp_gnt);
      cmp({tag, "_id"}, {5'd0, gnt_id_a}, v ? {5'd0, id} : 8'd0);
      cmp({tag, "_v"}, {7'd0, gnt_v_a}, {7'd0, v});
    end
  endtask

  // Drive req, queue the expected post-edge outputs, clock once, then pop and compare.
  task automatic step(input bit sel, input logic [7:0] r, input logic v, input logic [2:0] id,
                      input string tag);
    exp_t e;
    if (sel) req_b = r; else req_a = r;
    sb.push_back('{sel, v, id, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(e.sel, e.v, e.id, e.tag);
  endtask

  task automatic do_reset(input string tag);
    req_a = '0;
    req_b = '0;
    #2 rst = 1'b1;
    #1;
    check_outputs(1'b0, 1'b0, 3'd0, {tag, "_a"});
    check_outputs(1'b1, 1'b0, 3'd0, {tag, "_b"});
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1: single requester, release advances ptr to 3
    do_reset("rst0");
    step(0, 8'h04, 1, 3'd2, "t1_grant");
    step(0, 8'h04, 1, 3'd2, "t1_hold");
    step(0, 8'h00, 0, 3'd0, "t1_rel");
    step(0, 8'h09, 1, 3'd3, "t1_ptr3");
    step(0, 8'h00, 0, 3'd0, "t1_rel2");

    // Test 2: two requesters, dead cycle, wrap of ptr after owner 7
    do_reset("rst2");
    step(0, 8'h81, 1, 3'd0, "t2_g0");
    step(0, 8'h81, 1, 3'd0, "t2_h0");
    step(0, 8'h80, 0, 3'd0, "t2_dead");
    step(0, 8'h80, 1, 3'd7, "t2_g7");
    step(0, 8'h00, 0, 3'd0, "t2_rel7");
    step(0, 8'h81, 1, 3'd0, "t2_wrap");
    // release with new requests at the same edge: release wins, then ptr=1 picks 7
    step(0, 8'h80, 0, 3'd0, "t2_relwin");
    step(0, 8'h80, 1, 3'd7, "t2_after");
    step(0, 8'h00, 0, 3'd0, "t2_end");

    // Test 3: MAX_HOLD=4 alternation between 3 and 5
    do_reset("rst3");
    for (int i = 0; i < 4; i++) step(1, 8'h28, 1, 3'd3, "t3_a3");
    step(1, 8'h28, 0, 3'd0, "t3_dead1");
    for (int i = 0; i < 4; i++) step(1, 8'h28, 1, 3'd5, "t3_a5");
    step(1, 8'h28, 0, 3'd0, "t3_dead2");
    step(1, 8'h28, 1, 3'd3, "t3_back3");

    // Test 4: sole requester re-granted after forced release
    do_reset("rst4");
    for (int i = 0; i < 4; i++) step(1, 8'h08, 1, 3'd3, "t4_first");
    step(1, 8'h08, 0, 3'd0, "t4_dead");
    for (int i = 0; i < 4; i++) step(1, 8'h08, 1, 3'd3, "t4_second");
    step(1, 8'h00, 0, 3'd0, "t4_dead2");

    // Test 5: async reset mid-grant, resume from ptr=0
    do_reset("rst5");
    step(0, 8'h40, 1, 3'd6, "t5_g6");
    step(0, 8'h40, 1, 3'd6, "t5_h6");
    #2 rst = 1'b1;
    #1;
    check_outputs(1'b0, 1'b0, 3'd0, "t5_async");
    req_a = 8'h42;
    @(negedge clk);
    rst = 1'b0;
    step(0, 8'h42, 1, 3'd1, "t5_resume");
    step(0, 8'h00, 0, 3'd0, "t5_rel");

    // Test 6: unlimited hold for 300 cycles, counter saturates
    do_reset("rst6");
    for (int i = 0; i < 300; i++) step(0, 8'h10, 1, 3'd4, "t6_hold");
    cmp("t6_sat", dut_a.hold_cnt, 8'd255);
    step(0, 8'h00, 0, 3'd0, "t6_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
